slew_limiter: RTL and testbench

SLEW_LIMITER -- requirements
Module: slew_limiter

---
 rtl/slew_limiter.sv | 141 ++++++++++++++
 tb/tb_slew_limiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/slew_limiter.sv
// slew_limiter: four-channel output slew-rate limiter.
//
// Each sample_clk rise starts a six-cycle frame. The per-channel targets are
// captured on the rise (zero for unpatched inputs). One shared
// subtract/compare path then walks the four accumulators toward their
// targets by at most STEP LSBs each. All four outputs update together on
// the last cycle of the frame.
//
// Parameters:
//   W    - signed sample width in bits
//   STEP - largest change per sample in LSBs, 1 .. 2^(W-1)-1
// Ports:
//   clk            - clock; all state changes on its rising edge
//   rst            - asynchronous active-high reset
//   sample_clk     - sample-rate strobe, sampled in the clk domain
//   sample_in0..3  - signed input samples, one per channel
//   jack           - jack-detect bits; bit n high means input n is patched
//   sample_out0..3 - signed slew-limited output samples
//   overrun        - sticky; set when a strobe rise arrives mid-frame
module slew_limiter #(
    parameter int unsigned W    = 16,
    parameter int unsigned STEP = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    input  logic [7:0]          jack,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    output logic                overrun
);

    typedef enum logic [2:0] {StIdle, StCh0, StCh1, StCh2, StCh3, StCommit} state_e;

    localparam logic signed [W:0]   StepWide = (W+1)'(STEP);
    localparam logic signed [W:0]   StepNeg  = -StepWide;
    localparam logic signed [W-1:0] StepW    = W'(STEP);

    state_e              state_q, state_d;
    logic                sclk_d;
    logic                rise;
    logic                overrun_q;
    logic signed [W-1:0] target_q [4];
    logic signed [W-1:0] acc_q    [4];
    logic signed [W-1:0] out_q    [4];
    logic signed [W-1:0] in_vec   [4];

    // Shared update path, steered by the FSM
    logic [1:0]          ch;
    logic                ch_active;
    logic signed [W-1:0] cur_tgt, cur_acc, acc_next;
    logic signed [W:0]   diff;

    // Only the low four jack bits map to channels
    logic                unused_jack;
    assign unused_jack = ^jack[7:4];

    assign rise = sample_clk & ~sclk_d;

    assign in_vec[0] = sample_in0;
    assign in_vec[1] = sample_in1;
    assign in_vec[2] = sample_in2;
    assign in_vec[3] = sample_in3;

    always_comb begin
        state_d   = state_q;
        ch        = 2'd0;
        ch_active = 1'b0;
        unique case (state_q)
            StIdle:   if (rise) state_d = StCh0;
            StCh0:    begin ch = 2'd0; ch_active = 1'b1; state_d = StCh1;    end
            StCh1:    begin ch = 2'd1; ch_active = 1'b1; state_d = StCh2;    end
            StCh2:    begin ch = 2'd2; ch_active = 1'b1; state_d = StCh3;    end
            StCh3:    begin ch = 2'd3; ch_active = 1'b1; state_d = StCommit; end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Difference is one bit wider so a full-scale swing cannot wrap; the
    // accumulator sum stays in range because it only moves toward a legal
    // target and never overshoots it.
    always_comb begin
        cur_tgt = target_q[ch];
        cur_acc = acc_q[ch];
        diff    = {cur_tgt[W-1], cur_tgt} - {cur_acc[W-1], cur_acc};
        if (diff > StepWide) begin
            acc_next = cur_acc + StepW;
        end else if (diff < StepNeg) begin
            acc_next = cur_acc - StepW;
        end else begin
            acc_next = cur_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            // Reset high so a strobe already high at release is not a rise
            sclk_d    <= 1'b1;
            overrun_q <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                target_q[n] <= '0;
                acc_q[n]    <= '0;
                out_q[n]    <= '0;
            end
        end else begin
            state_q <= state_d;
            sclk_d  <= sample_clk;
            if (rise && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
            if (rise && state_q == StIdle) begin
                for (int n = 0; n < 4; n++) begin
                    target_q[n] <= jack[n] ? in_vec[n] : '0;
                end
            end
            if (ch_active) begin
                acc_q[ch] <= acc_next;
            end
            if (state_q == StCommit) begin
                for (int n = 0; n < 4; n++) begin
                    out_q[n] <= acc_q[n];
                end
            end
        end
    end

    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_slew_limiter.sv
// Bench for slew_limiter: table of known frames, hand-written corner cases
// (full-scale swing, overrun, reset mid-frame) and randomized frames checked
// against an arithmetic reference model.
module tb_slew_limiter;

    localparam int W    = 16;
    localparam int STEP = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                sample_clk;
    logic signed [W-1:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic [7:0]          jack;
    logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic                overrun;
    logic signed [W-1:0] outs [4];

    assign outs[0] = sample_out0;
    assign outs[1] = sample_out1;
    assign outs[2] = sample_out2;
    assign outs[3] = sample_out3;

    slew_limiter #(.W(W), .STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_clk (sample_clk),
        .sample_in0 (sample_in0),
        .sample_in1 (sample_in1),
        .sample_in2 (sample_in2),
        .sample_in3 (sample_in3),
        .jack       (jack),
        .sample_out0(sample_out0),
        .sample_out1(sample_out1),
        .sample_out2(sample_out2),
        .sample_out3(sample_out3),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_acc [4];   // reference accumulators
    int prev  [4];   // outputs expected before the next commit

    typedef struct {
        logic [3:0] jk;
        int         din [4];
        int         dexp[4];
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] j, input int a, input int b, input int c,
                          input int d);
        jack       = {4'h0, j};
        sample_in0 = W'(a);
        sample_in1 = W'(b);
        sample_in2 = W'(c);
        sample_in3 = W'(d);
    endtask

    // Reference: each channel moves toward its target by at most STEP
    function automatic void model_step();
        int tgt [4];
        int d;
        tgt[0] = jack[0] ? int'(sample_in0) : 0;
        tgt[1] = jack[1] ? int'(sample_in1) : 0;
        tgt[2] = jack[2] ? int'(sample_in2) : 0;
        tgt[3] = jack[3] ? int'(sample_in3) : 0;
        for (int n = 0; n < 4; n++) begin
            d = tgt[n] - m_acc[n];
            if (d > STEP)       m_acc[n] = m_acc[n] + STEP;
            else if (d < -STEP) m_acc[n] = m_acc[n] - STEP;
            else                m_acc[n] = tgt[n];
        end
    endfunction

    // One frame: strobe pulse, inputs scrambled after capture, outputs must
    // hold through edge 4 and take the new values on edge 5.
    task automatic frame(input string name, input int e0, input int e1, input int e2,
                         input int e3);
        logic [7:0]          sj;
        logic signed [W-1:0] s0, s1, s2, s3;
        int                  e [4];
        e = '{e0, e1, e2, e3};
        sj = jack; s0 = sample_in0; s1 = sample_in1; s2 = sample_in2; s3 = sample_in3;
        @(posedge clk); #1 sample_clk = 1'b1;
        @(posedge clk); #1 sample_clk = 1'b0;   // capture edge 0
        jack       = 8'($urandom);
        sample_in0 = W'($urandom);
        sample_in1 = W'($urandom);
        sample_in2 = W'($urandom);
        sample_in3 = W'($urandom);
        repeat (4) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) chk($sformatf("%s hold out%0d", name, n), outs[n], prev[n]);
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) chk($sformatf("%s out%0d", name, n), outs[n], e[n]);
        prev = e;
        jack = sj; sample_in0 = s0; sample_in1 = s1; sample_in2 = s2; sample_in3 = s3;
    endtask

    task automatic model_frame(input string name);
        model_step();
        frame(name, m_acc[0], m_acc[1], m_acc[2], m_acc[3]);
    endtask

    function automatic int clip(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    initial begin
        // Frames 1..20: ramp to 1000, small negative step, rise to 640 then decay
        for (int i = 0; i < 20; i++) begin
            int k;
            k = i + 1;
            tbl[i].jk      = (k <= 10) ? 4'b0111 : 4'b0011;
            tbl[i].din[0]  = 1000;
            tbl[i].din[1]  = -100;
            tbl[i].din[2]  = (k <= 10) ? 640 : 5000;
            tbl[i].din[3]  = 12345;
            tbl[i].dexp[0] = (64 * k < 1000) ? 64 * k : 1000;
            tbl[i].dexp[1] = (k == 1) ? -64 : -100;
            tbl[i].dexp[2] = (k <= 10) ? 64 * k : 640 - 64 * (k - 10);
            tbl[i].dexp[3] = 0;
        end

        rst = 1'b1;
        sample_clk = 1'b0;
        set_in(4'b0000, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) chk($sformatf("reset out%0d", n), outs[n], 0);
        chk("reset overrun", overrun, 0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin m_acc[n] = 0; prev[n] = 0; end

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].jk, tbl[i].din[0], tbl[i].din[1], tbl[i].din[2], tbl[i].din[3]);
            frame($sformatf("table%0d", i + 1), tbl[i].dexp[0], tbl[i].dexp[1],
                  tbl[i].dexp[2], tbl[i].dexp[3]);
        end
        chk("table overrun", overrun, 0);
        m_acc = '{1000, -100, 0, 0};

        // Drive channel 3 to negative full scale, then swing to positive
        set_in(4'b1000, 0, 0, 0, -32768);
        for (int i = 0; i < 520; i++) model_frame("to_min");
        chk("at_min out3", sample_out3, -32768);
        set_in(4'b1000, 0, 0, 0, 32767);
        model_frame("swing");
        chk("swing out3", sample_out3, -32704);
        for (int i = 0; i < 3; i++) model_frame("swing_rise");

        // Randomized frames with random gaps
        for (int i = 0; i < 60; i++) begin
            int v [4];
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(1) == 0) v[n] = int'($urandom_range(65535)) - 32768;
                else v[n] = clip(m_acc[n] + int'($urandom_range(300)) - 150);
            end
            set_in(4'($urandom), v[0], v[1], v[2], v[3]);
            repeat ($urandom_range(3)) @(posedge clk);
            model_frame("random");
        end

        // Overrun: second rise 3 clk after the first is ignored
        set_in(4'b1111, 100, 200, 300, 400);
        model_step();
        @(posedge clk); #1 sample_clk = 1'b1;
        @(posedge clk); #1 sample_clk = 1'b0;
        set_in(4'b1111, -5000, -5000, -5000, -5000);
        @(posedge clk);
        @(posedge clk); #1 sample_clk = 1'b1;
        @(posedge clk); #1 sample_clk = 1'b0;
        chk("overrun set", overrun, 1);
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) chk($sformatf("overrun out%0d", n), outs[n], m_acc[n]);
        repeat (12) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++)
            chk($sformatf("overrun no_restart out%0d", n), outs[n], m_acc[n]);
        for (int n = 0; n < 4; n++) prev[n] = m_acc[n];
        set_in(4'b0101, 50, 0, -50, 0);
        model_frame("after_overrun");
        chk("overrun sticky", overrun, 1);

        // Reset during CH2, released with the strobe still high
        set_in(4'b1111, 3000, 3000, 3000, 3000);
        @(posedge clk); #1 sample_clk = 1'b1;
        @(posedge clk); #1 sample_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 sample_clk = 1'b1;
        rst = 1'b1;
        #1;
        for (int n = 0; n < 4; n++) chk($sformatf("midreset out%0d", n), outs[n], 0);
        chk("midreset overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) chk($sformatf("no_false_frame out%0d", n), outs[n], 0);
        sample_clk = 1'b0;
        for (int n = 0; n < 4; n++) begin m_acc[n] = 0; prev[n] = 0; end
        model_frame("post_reset");
        chk("post_reset out0", sample_out0, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
